// File: rtl/alu_issue_unit_if.sv
// Instruction handshake, ALU port and writeback bundle between the issue unit and its neighbours.
interface alu_issue_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [XLEN-1:0] alu_rd;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            illegal;

    modport slave (
        input  instr_valid, instr, alu_rd,
        output instr_ready, alu_funct3, alu_funct7, alu_rs1, alu_rs2,
               wb_valid, wb_addr, wb_data, illegal
    );

    modport master (
        output instr_valid, instr, alu_rd,
        input  instr_ready, alu_funct3, alu_funct7, alu_rs1, alu_rs2,
               wb_valid, wb_addr, wb_data, illegal
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Sequential OP/OP-IMM issue and writeback front end for the RV64 integer ALU.
// One instruction in flight: IDLE -> DECODE -> EXEC -> WB, with illegal words dropped in DECODE.
module alu_issue_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_unit_if.slave     bus,
    input  logic [4:0]          dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [6:0]      funct7_q, funct7_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] regfile_q [NREGS];
    logic [XLEN-1:0] regfile_d [NREGS];

    logic            dec_legal;
    logic [6:0]      dec_f7;
    logic [XLEN-1:0] dec_rs2;

    wire [6:0] opcode = instr_q[6:0];
    wire [4:0] rd     = instr_q[11:7];
    wire [2:0] f3     = instr_q[14:12];
    wire [4:0] rs1    = instr_q[19:15];
    wire [4:0] rs2    = instr_q[24:20];
    wire [6:0] f7     = instr_q[31:25];

    // Immediate forms force funct7 to zero so ADDI can never alias SUB at the ALU.
    always_comb begin
        dec_legal = 1'b0;
        dec_f7    = '0;
        dec_rs2   = '0;
        if (opcode == OPC_OP) begin
            dec_legal = (f7 == '0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            dec_f7    = f7;
            dec_rs2   = regfile_q[rs2];
        end else if (opcode == OPC_OP_IMM) begin
            case (f3)
                3'b001: begin
                    dec_legal = (instr_q[31:26] == 6'b000000);
                    dec_rs2   = {{(XLEN-6){1'b0}}, instr_q[25:20]};
                end
                3'b101: begin
                    dec_legal = (instr_q[31:26] == 6'b000000) || (instr_q[31:26] == 6'b010000);
                    dec_f7    = (instr_q[31:26] == 6'b010000) ? F7_ALT : '0;
                    dec_rs2   = {{(XLEN-6){1'b0}}, instr_q[25:20]};
                end
                default: begin
                    dec_legal = 1'b1;
                    dec_rs2   = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        regfile_d  = regfile_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    funct3_d = f3;
                    funct7_d = dec_f7;
                    rs1_d    = regfile_q[rs1];
                    rs2_d    = dec_rs2;
                    state_d  = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_EXEC: begin
                wb_valid_d = 1'b1;
                wb_addr_d  = rd;
                wb_data_d  = bus.alu_rd;
                if (rd != '0) regfile_d[rd] = bus.alu_rd;
                state_d = S_WB;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
            regfile_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
            regfile_q  <= regfile_d;
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.alu_funct3  = funct3_q;
    assign bus.alu_funct7  = funct7_q;
    assign bus.alu_rs1     = rs1_q;
    assign bus.alu_rs2     = rs2_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.illegal     = illegal_q;
    assign dbg_data        = (dbg_addr == '0) ? '0 : regfile_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural RV64 ALU hanging off the ALU port.
module tb_alu_issue_unit;
    logic        clk;
    logic        rst_n;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;
    int          passed;
    int          total;
    logic [63:0] exp_rf [32];

    alu_issue_unit_if #(.XLEN(64)) bus ();

    alu_issue_unit #(.XLEN(64), .NREGS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] alu_f(input logic [2:0] fn3, input logic [6:0] fn7,
                                          input logic [63:0] a, input logic [63:0] b);
        case (fn3)
            3'b000:  return fn7[5] ? a - b : a + b;
            3'b001:  return a << b[5:0];
            3'b010:  return {63'd0, $signed(a) < $signed(b)};
            3'b011:  return {63'd0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return fn7[5] ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    assign bus.alu_rd = alu_f(bus.alu_funct3, bus.alu_funct7, bus.alu_rs1, bus.alu_rs2);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a falling edge with the unit idle; returns at the falling edge after WB.
    task automatic issue(input logic [31:0] w, input logic [6:0] ef7, input logic [63:0] ers2,
                         input logic [4:0] ea, input logic [63:0] ed);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        chk("ready_idle", 64'(bus.instr_ready), 64'd1);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("ready_decode", 64'(bus.instr_ready), 64'd0);
        chk("wbv_decode", 64'(bus.wb_valid), 64'd0);
        @(negedge clk);
        chk("exec_funct3", 64'(bus.alu_funct3), 64'(w[14:12]));
        chk("exec_funct7", 64'(bus.alu_funct7), 64'(ef7));
        chk("exec_rs2", bus.alu_rs2, ers2);
        chk("ready_exec", 64'(bus.instr_ready), 64'd0);
        @(negedge clk);
        chk("wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("wb_addr", 64'(bus.wb_addr), 64'(ea));
        chk("wb_data", bus.wb_data, ed);
        dbg_addr = ea;
        #1 chk("dbg_after_wb", dbg_data, (ea == 5'd0) ? 64'd0 : ed);
        @(negedge clk);
        chk("wbv_after", 64'(bus.wb_valid), 64'd0);
        chk("ready_after", 64'(bus.instr_ready), 64'd1);
    endtask

    task automatic issue_illegal(input logic [31:0] w);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("ill_decode", 64'(bus.illegal), 64'd0);
        @(negedge clk);
        chk("ill_pulse", 64'(bus.illegal), 64'd1);
        chk("ill_ready", 64'(bus.instr_ready), 64'd1);
        chk("ill_no_wb", 64'(bus.wb_valid), 64'd0);
        @(negedge clk);
        chk("ill_drop", 64'(bus.illegal), 64'd0);
        chk("ill_no_wb2", 64'(bus.wb_valid), 64'd0);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1 chk(tag, dbg_data, exp_rf[i]);
        end
    endtask

    initial begin
        passed          = 0;
        total           = 0;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        dbg_addr        = '0;
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;

        @(negedge clk);
        chk("rst_ready", 64'(bus.instr_ready), 64'd1);
        chk("rst_wbv", 64'(bus.wb_valid), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        chk("rst_rs1", bus.alu_rs1, 64'd0);
        chk("rst_wbdata", bus.wb_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h00500093, 7'h00, 64'd5, 5'd1, 64'd5);
        issue(32'h00300113, 7'h00, 64'd3, 5'd2, 64'd3);
        issue(32'h002081B3, 7'h00, 64'd3, 5'd3, 64'd8);
        issue(32'h40208233, 7'h20, 64'd3, 5'd4, 64'd2);
        issue(32'hFFF00293, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(32'h0012A333, 7'h00, 64'd5, 5'd6, 64'd1);
        issue(32'h0012B3B3, 7'h00, 64'd5, 5'd7, 64'd0);
        issue(32'h4012D413, 7'h20, 64'd1, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(32'h00309493, 7'h00, 64'd3, 5'd9, 64'h28);
        issue(32'h00700013, 7'h00, 64'd7, 5'd0, 64'd7);
        exp_rf[1] = 64'd5;
        exp_rf[2] = 64'd3;
        exp_rf[3] = 64'd8;
        exp_rf[4] = 64'd2;
        exp_rf[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_rf[6] = 64'd1;
        exp_rf[8] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_rf[9] = 64'h28;

        issue_illegal(32'h40209233);
        issue_illegal(32'h00000003);
        sweep("rf_after_illegal");

        // Back-to-back: valid stays high, next word offered only once the first is taken.
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h01100513;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("b2b_ready_low_a", 64'(bus.instr_ready), 64'd0);
        end
        chk("b2b_wb_a_addr", 64'(bus.wb_addr), 64'd10);
        chk("b2b_wb_a_data", bus.wb_data, 64'h11);
        @(negedge clk);
        chk("b2b_ready_a", 64'(bus.instr_ready), 64'd1);
        chk("b2b_no_dup_wb", 64'(bus.wb_valid), 64'd0);
        bus.instr = 32'h02200593;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("b2b_ready_low_b", 64'(bus.instr_ready), 64'd0);
        end
        chk("b2b_wb_b_v", 64'(bus.wb_valid), 64'd1);
        chk("b2b_wb_b_addr", 64'(bus.wb_addr), 64'd11);
        chk("b2b_wb_b_data", bus.wb_data, 64'h22);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", 64'(bus.instr_ready), 64'd1);
        exp_rf[10] = 64'h11;
        exp_rf[11] = 64'h22;
        sweep("rf_after_b2b");

        // Asynchronous reset during EXEC of ADD x12,x1,x2.
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h00208633;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_rs1", bus.alu_rs1, 64'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rs1", bus.alu_rs1, 64'd0);
        chk("arst_rs2", bus.alu_rs2, 64'd0);
        chk("arst_funct7", 64'(bus.alu_funct7), 64'd0);
        chk("arst_ready", 64'(bus.instr_ready), 64'd1);
        chk("arst_wbv", 64'(bus.wb_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_no_wb", 64'(bus.wb_valid), 64'd0);
        end
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        sweep("rf_after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential issue/writeback front end for the 64-bit RV64 integer ALU. It accepts one 32-bit OP or OP-IMM instruction at a time over a valid/ready handshake and reads operands from an internal 32x64 register file. It drives the ALU's funct3/funct7/rs1/rs2 inputs, captures the ALU's combinational rd result, and writes it back. It is the producer/consumer on the other side of the ALU port and sits between fetch/decode and the ALU in the sequential core.

## Interface
- XLEN, 64, datapath width (ALU operand/result width)
- NREGS, 32, architectural registers; x0 hardwired to zero
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr  in  32  RV64I instruction word
- instr_ready  out  1  unit can accept; high only in IDLE
- alu_funct3  out  3  registered funct3 to ALU
- alu_funct7  out  7  registered funct7 to ALU
- alu_rs1  out  XLEN  registered operand A to ALU
- alu_rs2  out  XLEN  registered operand B (register or sign-extended imm/shamt)
- alu_rd  in  XLEN  combinational ALU result
- wb_valid  out  1  one-cycle writeback strobe
- wb_addr  out  5  destination register of strobed writeback
- wb_data  out  XLEN  written value
- illegal  out  1  one-cycle strobe: instruction rejected
- dbg_addr  in  5  debug read address
- dbg_data  out  XLEN  combinational regfile read; 0 when dbg_addr==0

## Operation
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE. Illegal path: DECODE -> IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE.
- DECODE: read regfile[rs1], regfile[rs2], check legality. Legal: register alu_* and go to EXEC. Illegal: go to IDLE with illegal=1 for the next cycle.
- OP (opcode 0110011): funct7 0000000 is legal for any funct3. funct7 0100000 is legal only for funct3 000 (SUB) and 101 (SRA). alu_rs2=regfile[rs2], alu_funct7=instr[31:25].
- OP-IMM (opcode 0010011):
  - funct3 000/010/011/100/110/111: alu_rs2 = sign-extend(instr[31:20]) to 64; alu_funct7 forced 0000000, so ADDI never becomes SUB.
  - funct3 001: instr[31:26] must be 000000; alu_rs2 = zero-extend(instr[25:20]); funct7 0000000.
  - funct3 101: instr[31:26] 000000 gives SRLI (funct7 0000000); 010000 gives SRAI (funct7 0100000); any other value is illegal. alu_rs2 = zero-extend(instr[25:20]).
- Any other opcode is illegal. Illegal instructions cause no regfile change and no wb_valid.
- EXEC: alu_* held stable. At the end of EXEC, alu_rd is captured into wb_data, wb_addr=instr[11:7], and regfile[rd] is written unless rd==0.
- WB: wb_valid=1 for exactly this cycle; then IDLE. wb_valid also pulses for rd==0, with the ALU value on wb_data, but x0 is not written.
- Reads in DECODE see all previous writebacks, so there are no hazards and no bypass.
- Reset (async, any state): state=IDLE; regfile, alu_*, wb_*, and illegal all 0; instr_ready=1. An in-flight instruction is discarded and no wb_valid is produced.

## Timing
- Accept edge E0. DECODE is the cycle after E0. alu_* are valid from E1 through E2. Regfile write at E2. wb_valid is high E2–E3. instr_ready returns high after E3.
- Legal instruction: 4-cycle occupancy, 1 instruction per 4 cycles max. Writeback latency: 2 edges after accept (E2).
- Illegal instruction: illegal is high E1–E2 and instr_ready is high in the same cycle. A new instruction may be accepted at E2.
- instr_ready is low in DECODE, EXEC, and WB. instr_valid in those states is ignored and the instruction is not consumed. The initiator holds instr until accepted.
- alu_rd is sampled only at the EXEC→WB edge. The ALU is purely combinational, with a 1-cycle budget.

## Test plan
- ADDI x1,x0,5 (0x00500093), ADDI x2,x0,3 (0x00300113), ADD x3,x1,x2 (0x002081B3), SUB x4,x1,x2 (0x40208233) -> wb x1=5, x2=3, x3=8, x4=2. During SUB's EXEC, alu_funct7=0100000; during ADDI's EXEC, alu_funct7=0000000.
- ADDI x5,x0,-1 (0xFFF00293), SLT x6,x5,x1 (0x0012A333), SLTU x7,x5,x1 (0x0012B3B3) -> x5=FFFFFFFFFFFFFFFF, x6=1, x7=0.
- SRAI x8,x5,1 (0x4012D413) -> alu_funct7=0100000, alu_rs2=1, x8=FFFFFFFFFFFFFFFF. SLLI x9,x1,3 (0x00309493) -> x9=0x28.
- ADDI x0,x0,7 (0x00700013) -> wb_valid with wb_addr=0, and dbg_data at addr 0 stays 0. Also 0x40209233 and 0x00000003 -> each gives an illegal pulse, no wb_valid, and all regs unchanged by dbg sweep.
- instr_valid held high with back-to-back legal instructions -> accepts exactly 4 cycles apart. instr_ready is low for 3 cycles after each accept, and the instruction word is not consumed early.
- rst_n pulled low asynchronously mid-EXEC of ADD -> outputs 0 immediately, instr_ready=1, no wb_valid, and all registers read 0 after release.
